door_dwell_timer: RTL and testbench

//  Parametrised elevator door dwell timer with a cascaded-BCD elapsed count. Started by car arrival.

---
 rtl/door_dwell_timer_pkg.sv | 29 ++
 rtl/bcd_decade_cnt.sv | 26 ++
 rtl/door_dwell_timer.sv | 140 ++++++++++++++
 tb/tb_door_dwell_timer.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/door_dwell_timer_pkg.sv
// Shared definitions for the elevator door dwell timer: FSM state encoding
// and a helper that turns a binary constant into packed BCD so the top level
// can compare the running BCD count against its thresholds directly.
package door_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        OPEN  = 2'd1,
        HOLD  = 2'd2,
        CLOSE = 2'd3
    } door_state_t;

    // Widest count the helper can express; BCD_DIGITS must not exceed this.
    localparam int MAX_BCD_DIGITS = 8;

    // Binary to packed BCD, digit 0 in [3:0]. Only ever evaluated on constants.
    function automatic logic [4*MAX_BCD_DIGITS-1:0] to_bcd(input int unsigned value);
        logic [4*MAX_BCD_DIGITS-1:0] result;
        int unsigned                 rem;
        result = '0;
        rem    = value;
        for (int i = 0; i < MAX_BCD_DIGITS; i++) begin
            result[4*i +: 4] = 4'(rem % 10);
            rem              = rem / 10;
        end
        return result;
    endfunction

endpackage

// File: rtl/bcd_decade_cnt.sv
// One decade of the cascaded BCD elapsed counter. Counts 0..9 when enabled,
// wraps to 0 after 9; carry flags the digit sitting at 9 so the next digit
// up can be enabled on the same cycle this one rolls over.
module bcd_decade_cnt (
    input  logic       clk,
    input  logic       rst,
    input  logic       clr,
    input  logic       en,
    output logic [3:0] q,
    output logic       carry
);

    // Decade register: synchronous clear has priority over counting.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q <= 4'd0;
        end else if (clr) begin
            q <= 4'd0;
        end else if (en) begin
            q <= (q == 4'd9) ? 4'd0 : q + 4'd1;
        end
    end

    assign carry = (q == 4'd9);

endmodule

// File: rtl/door_dwell_timer.sv
// Elevator door dwell timer. A rising edge on arr opens the door and starts a
// BCD elapsed count; the door closes when the count reaches DWELL_TICKS-1,
// or earlier on close_req once MIN_TICKS has elapsed. open_req holds the door
// (count parked at 0). All outputs are registered.
module door_dwell_timer #(
    parameter int DWELL_TICKS = 100,
    parameter int MIN_TICKS   = 25,
    parameter int BCD_DIGITS  = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    arr,
    input  logic                    open_req,
    input  logic                    close_req,
    output logic                    door_open,
    output logic                    close_go,
    output logic                    busy,
    output logic [4*BCD_DIGITS-1:0] elapsed_bcd
);

    import door_pkg::*;

    localparam int BW = 4*BCD_DIGITS;

    // Thresholds pre-converted to BCD; BCD ordering matches numeric ordering,
    // so plain unsigned compares work on the packed digits.
    localparam logic [4*MAX_BCD_DIGITS-1:0] LAST_FULL = to_bcd(DWELL_TICKS - 1);
    localparam logic [4*MAX_BCD_DIGITS-1:0] MIN_FULL  = to_bcd(MIN_TICKS);
    localparam logic [BW-1:0]               LAST_BCD  = LAST_FULL[BW-1:0];
    localparam logic [BW-1:0]               MIN_BCD   = MIN_FULL[BW-1:0];

    door_state_t          state;
    logic                 arr_d;
    logic                 arr_edge;
    logic                 at_last;
    logic                 close_early;
    logic                 all_nines;
    logic                 cnt_en;
    logic                 cnt_clr;
    logic [BCD_DIGITS-1:0] carry;
    logic [BCD_DIGITS-1:0] en_chain;

    assign arr_edge    = arr & ~arr_d;
    assign at_last     = (elapsed_bcd == LAST_BCD);
    assign close_early = close_req & (elapsed_bcd >= MIN_BCD);
    // Every digit at 9: the counter must never roll over from here.
    assign all_nines   = &carry;

    // Registered copy of arr for arrival edge detection.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            arr_d <= 1'b0;
        end else begin
            arr_d <= arr;
        end
    end

    // Counter control: count only while OPEN and not leaving OPEN this cycle,
    // so the final value is held through the CLOSE cycle.
    always_comb begin
        cnt_en  = 1'b0;
        cnt_clr = 1'b0;
        case (state)
            OPEN: begin
                if (arr_edge || open_req) begin
                    cnt_clr = 1'b1;
                end else if (!close_early && !at_last && !all_nines) begin
                    cnt_en = 1'b1;
                end
            end
            default: cnt_clr = (state != CLOSE) || 1'b1;
        endcase
    end

    // Cascaded decades: a digit advances only when all lower digits carry.
    generate
        for (genvar gi = 0; gi < BCD_DIGITS; gi++) begin : g_digit
            if (gi == 0) begin : g_lsd
                assign en_chain[gi] = cnt_en;
            end else begin : g_upper
                assign en_chain[gi] = en_chain[gi-1] & carry[gi-1];
            end
            bcd_decade_cnt u_digit (
                .clk   (clk),
                .rst   (rst),
                .clr   (cnt_clr),
                .en    (en_chain[gi]),
                .q     (elapsed_bcd[4*gi +: 4]),
                .carry (carry[gi])
            );
        end
    endgenerate

    // Door FSM with registered door_open / close_go / busy.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            door_open <= 1'b0;
            close_go  <= 1'b0;
            busy      <= 1'b0;
        end else begin
            close_go <= 1'b0;
            case (state)
                IDLE: begin
                    if (arr_edge) begin
                        state     <= OPEN;
                        door_open <= 1'b1;
                        busy      <= 1'b1;
                    end
                end
                OPEN: begin
                    if (arr_edge) begin
                        state <= OPEN;
                    end else if (open_req) begin
                        state <= HOLD;
                    end else if (close_early || at_last) begin
                        state     <= CLOSE;
                        door_open <= 1'b0;
                        close_go  <= 1'b1;
                    end
                end
                HOLD: begin
                    if (!open_req) begin
                        state <= OPEN;
                    end
                end
                CLOSE: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                default: begin
                    state     <= IDLE;
                    door_open <= 1'b0;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_door_dwell_timer.sv
// Bench for door_dwell_timer: directed scenarios followed by random button and
// arrival activity, all checked every cycle against a cycle-level behavioural
// model of the door, plus a short check of a 7-tick single-digit build.
module tb_door_dwell_timer;

    localparam int D  = 100;
    localparam int M  = 25;
    localparam int D2 = 7;
    localparam int M2 = 3;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       arr = 1'b0, open_req = 1'b0, close_req = 1'b0;
    logic       door_open, close_go, busy;
    logic [7:0] elapsed_bcd;

    logic       arr2 = 1'b0, open2 = 1'b0, close2 = 1'b0;
    logic       door2, go2, busy2;
    logic [3:0] bcd2;

    always #5 clk = ~clk;

    door_dwell_timer #(.DWELL_TICKS(D), .MIN_TICKS(M), .BCD_DIGITS(2)) dut (
        .clk(clk), .rst(rst), .arr(arr), .open_req(open_req), .close_req(close_req),
        .door_open(door_open), .close_go(close_go), .busy(busy), .elapsed_bcd(elapsed_bcd)
    );

    door_dwell_timer #(.DWELL_TICKS(D2), .MIN_TICKS(M2), .BCD_DIGITS(1)) dut_small (
        .clk(clk), .rst(rst), .arr(arr2), .open_req(open2), .close_req(close2),
        .door_open(door2), .close_go(go2), .busy(busy2), .elapsed_bcd(bcd2)
    );

    int n_cmp = 0;
    int n_err = 0;

    // Reference model: door open flag, hold flag, closing-cycle flag, elapsed integer.
    bit m_door, m_hold, m_closing, m_arr_d;
    int m_cnt;
    int open_cycles, go_count;
    int door2_cycles, go2_tick;

    function automatic logic [7:0] to_bcd2(input int v);
        return 8'(((v / 10) % 10) * 16 + (v % 10));
    endfunction

    task automatic cmp(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_door = 0; m_hold = 0; m_closing = 0; m_arr_d = 0; m_cnt = 0;
    endtask

    // One clock edge of door behaviour, from the inputs present at that edge.
    task automatic model_step();
        bit edge_seen;
        if (rst) begin
            model_reset();
            return;
        end
        edge_seen = arr && !m_arr_d;
        if (m_closing) begin
            m_closing = 0; m_cnt = 0;
        end else if (!m_door) begin
            if (edge_seen) begin m_door = 1; m_cnt = 0; end
        end else if (m_hold) begin
            if (!open_req) begin m_hold = 0; m_cnt = 0; end
        end else if (edge_seen) begin
            m_cnt = 0;
        end else if (open_req) begin
            m_hold = 1; m_cnt = 0;
        end else if ((close_req && m_cnt >= M) || m_cnt == D - 1) begin
            m_door = 0; m_closing = 1;
        end else begin
            m_cnt++;
        end
        m_arr_d = arr;
    endtask

    task automatic check_all(input string tag);
        cmp({tag, ".door_open"}, 32'(door_open), 32'(m_door));
        cmp({tag, ".close_go"},  32'(close_go),  32'(m_closing));
        cmp({tag, ".busy"},      32'(busy),      32'(m_door || m_closing));
        cmp({tag, ".elapsed"},   32'(elapsed_bcd), 32'(to_bcd2(m_cnt)));
    endtask

    task automatic tick(input string tag);
        @(posedge clk);
        model_step();
        @(negedge clk);
        check_all(tag);
        if (door_open) open_cycles++;
        if (close_go)  go_count++;
    endtask

    task automatic run_to(input int n, input string tag);
        for (int i = 0; i < 300 && m_cnt != n; i++) tick(tag);
        cmp({tag, ".reached"}, 32'(elapsed_bcd), 32'(to_bcd2(n)));
    endtask

    task automatic finish_dwell(input string tag);
        for (int i = 0; i < 300 && (m_door || m_closing); i++) tick(tag);
        tick(tag);
        cmp({tag, ".idle"}, 32'(busy), 32'd0);
    endtask

    task automatic arrive(input string tag);
        arr = 1'b0;
        tick(tag);
        arr = 1'b1;
        open_cycles = 0;
        go_count    = 0;
        tick(tag);
    endtask

    initial begin
        int first_go;
        int bcd_at_go;
        int go_before;
        model_reset();

        // Reset state
        tick("reset");
        tick("reset");
        rst = 1'b0;
        tick("post_reset");

        // 1: plain dwell, 100 open cycles, close_go after edge k+100
        arrive("dwell");
        first_go = -1; bcd_at_go = -1;
        for (int t = 1; t <= 150; t++) begin
            tick("dwell");
            if (close_go && first_go < 0) begin
                first_go  = t;
                bcd_at_go = int'(elapsed_bcd);
            end
        end
        cmp("dwell.go_tick", 32'(first_go), 32'd100);
        cmp("dwell.open_cycles", 32'(open_cycles), 32'd100);
        cmp("dwell.go_count", 32'(go_count), 32'd1);
        cmp("dwell.bcd_at_go", 32'(bcd_at_go), 32'h99);

        // 2: hold at 40 for 30 cycles, close_go 100 edges after release edge
        arrive("hold");
        run_to(40, "hold");
        open_req = 1'b1;
        for (int i = 0; i < 30; i++) tick("hold_on");
        cmp("hold.parked", 32'(elapsed_bcd), 32'h00);
        open_req = 1'b0;
        tick("hold_release");
        first_go = -1;
        for (int t = 1; t <= 150 && first_go < 0; t++) begin
            tick("hold_after");
            if (close_go) first_go = t;
        end
        cmp("hold.go_tick", 32'(first_go), 32'd100);
        finish_dwell("hold_end");

        // 3: early close ignored at 10, honoured at 30
        arrive("early");
        run_to(10, "early");
        close_req = 1'b1;
        tick("early_ignored");
        close_req = 1'b0;
        cmp("early.ignored", 32'(close_go), 32'd0);
        run_to(30, "early");
        close_req = 1'b1;
        tick("early_close");
        close_req = 1'b0;
        cmp("early.go", 32'(close_go), 32'd1);
        cmp("early.open_cycles", 32'(open_cycles), 32'd31);
        finish_dwell("early_end");

        // 4: both buttons at 50: hold wins, no close_go
        arrive("both");
        run_to(50, "both");
        open_req = 1'b1; close_req = 1'b1;
        go_before = go_count;
        for (int i = 0; i < 20; i++) tick("both_held");
        cmp("both.no_go", 32'(go_count), 32'(go_before));
        cmp("both.door", 32'(door_open), 32'd1);
        open_req = 1'b0; close_req = 1'b0;
        finish_dwell("both_end");

        // 5: re-arrival at 60 restarts the count without dropping the door
        arrive("rearr");
        run_to(60, "rearr");
        arr = 1'b0;
        tick("rearr_low");
        arr = 1'b1;
        tick("rearr_high");
        cmp("rearr.count", 32'(elapsed_bcd), 32'h00);
        cmp("rearr.door", 32'(door_open), 32'd1);
        finish_dwell("rearr_end");

        // 6: async reset at 70 clears everything at once, no close_go later
        arrive("rst");
        run_to(70, "rst");
        rst = 1'b1;
        #1;
        model_reset();
        check_all("rst_async");
        arr = 1'b0;
        go_count = 0;
        tick("rst_hold");
        rst = 1'b0;
        for (int i = 0; i < 120; i++) tick("rst_after");
        cmp("rst.no_go", 32'(go_count), 32'd0);

        // Random activity against the model
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 99) < 3) arr = ~arr;
            if ($urandom_range(0, 99) < 4) open_req = ~open_req;
            close_req = ($urandom_range(0, 99) < 10);
            if ($urandom_range(0, 599) == 0) begin
                rst = 1'b1;
                #1;
                model_reset();
                check_all("rand_rst");
                tick("rand_rst_hold");
                rst = 1'b0;
            end else begin
                tick("rand");
            end
        end
        arr = 1'b0; open_req = 1'b0; close_req = 1'b0;
        finish_dwell("rand_end");

        // Small build: 7-tick dwell, single digit
        door2_cycles = 0; go2_tick = -1;
        arr2 = 1'b1;
        tick("small_arrive");
        if (door2) door2_cycles++;
        for (int t = 1; t <= 30; t++) begin
            tick("small");
            if (door2) door2_cycles++;
            if (go2 && go2_tick < 0) begin
                go2_tick = t;
                cmp("small.bcd_at_go", 32'(bcd2), 32'd6);
            end
        end
        cmp("small.go_tick", 32'(go2_tick), 32'(D2));
        cmp("small.open_cycles", 32'(door2_cycles), 32'(D2));
        cmp("small.idle", 32'(busy2), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
